// File: rtl/mac_overflow_monitor.sv
// mac_overflow_monitor: windowed per-lane MAC overflow event counters with sticky flags and read port.
// Optional saturation interrupt enabled by defining OVF_MON_IRQ_EN.
module mac_overflow_monitor #(
    parameter int LANES = 4,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16,
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [LANES-1:0] sum_pos_ovf,
    input  logic [LANES-1:0] sum_neg_ovf,
    input  logic [LANES-1:0] prod_pos_ovf,
    input  logic [LANES-1:0] prod_neg_ovf,
    input  logic [WIN_W-1:0] window_len,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic [LANES-1:0] sticky,
    input  logic             rd_req,
    input  logic [LW-1:0]    rd_lane,
    input  logic [1:0]       rd_sel,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             irq
);
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
    localparam logic [WIN_W-1:0] WMAX = {WIN_W{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, next;

    logic [CNT_W-1:0] cnt [4][LANES];
    logic [LANES-1:0] flags [4];
    logic [LANES-1:0] flags_any;
    logic [WIN_W-1:0] wcnt, wlen;
    logic go, fin, count;

    always_comb begin
        flags[0] = sum_pos_ovf;
        flags[1] = sum_neg_ovf;
        flags[2] = prod_pos_ovf;
        flags[3] = prod_neg_ovf;
        flags_any = sum_pos_ovf | sum_neg_ovf | prod_pos_ovf | prod_neg_ovf;
    end

    // stop and window end in the same cycle collapse into one transition
    always_comb begin
        go = state != RUN && start;
        fin = state == RUN && (stop || (valid_in && wlen != '0 && wcnt + 1'b1 == wlen));
        count = state == RUN && valid_in;
        next = go ? RUN : fin ? DONE : state;
    end

    assign busy = state == RUN;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            done <= 1'b0;
            wcnt <= '0;
            wlen <= '0;
            sticky <= '0;
            rd_valid <= 1'b0;
            rd_data <= '0;
            for (int t = 0; t < 4; t++)
                for (int l = 0; l < LANES; l++)
                    cnt[t][l] <= '0;
        end else begin
            state <= next;
            done <= fin;
            rd_valid <= rd_req;
            // registered read returns the pre-update value
            rd_data <= (rd_req && 32'(rd_lane) < LANES) ? cnt[rd_sel][rd_lane] : '0;
            if (go) begin
                wcnt <= '0;
                wlen <= window_len;
                sticky <= '0;
                for (int t = 0; t < 4; t++)
                    for (int l = 0; l < LANES; l++)
                        cnt[t][l] <= '0;
            end else if (count) begin
                wcnt <= wcnt + WIN_W'(wcnt != WMAX);
                sticky <= sticky | flags_any;
                for (int t = 0; t < 4; t++)
                    for (int l = 0; l < LANES; l++)
                        if (flags[t][l] && cnt[t][l] != CMAX)
                            cnt[t][l] <= cnt[t][l] + 1'b1;
            end
        end
    end

`ifdef OVF_MON_IRQ_EN
    logic sat;

    always_comb begin
        sat = 1'b0;
        for (int t = 0; t < 4; t++)
            for (int l = 0; l < LANES; l++)
                sat = sat | (cnt[t][l] == CMAX);
    end

    always_ff @(posedge clk) begin
        if (!reset || go)
            irq <= 1'b0;
        else if (sat)
            irq <= 1'b1;
    end
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_mac_overflow_monitor.sv
// tb_mac_overflow_monitor: directed self-checking bench, small counters so saturation is reachable.
module tb_mac_overflow_monitor;
    localparam int LANES = 4;
    localparam int CNT_W = 4;
    localparam int WIN_W = 16;

    logic clk = 1'b0;
    logic reset, valid_in, start, stop, rd_req;
    logic [LANES-1:0] sum_pos_ovf, sum_neg_ovf, prod_pos_ovf, prod_neg_ovf;
    logic [WIN_W-1:0] window_len;
    logic [1:0] rd_lane, rd_sel;
    logic busy, done, rd_valid, irq;
    logic [LANES-1:0] sticky;
    logic [CNT_W-1:0] rd_data;
    int total = 0;
    int fails = 0;
    logic irq_exp;

    mac_overflow_monitor #(.LANES(LANES), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .sum_pos_ovf(sum_pos_ovf), .sum_neg_ovf(sum_neg_ovf),
        .prod_pos_ovf(prod_pos_ovf), .prod_neg_ovf(prod_neg_ovf),
        .window_len(window_len), .start(start), .stop(stop),
        .busy(busy), .done(done), .sticky(sticky),
        .rd_req(rd_req), .rd_lane(rd_lane), .rd_sel(rd_sel),
        .rd_valid(rd_valid), .rd_data(rd_data), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_flags();
        sum_pos_ovf = '0;
        sum_neg_ovf = '0;
        prod_pos_ovf = '0;
        prod_neg_ovf = '0;
    endtask

    task automatic rd(input int lane, input int sel, input int exp, input string tag);
        rd_req = 1'b1;
        rd_lane = 2'(lane);
        rd_sel = 2'(sel);
        tick();
        check({tag, "_v"}, 32'(rd_valid), 1);
        check(tag, 32'(rd_data), exp);
    endtask

    task automatic begin_win(input int len);
        window_len = WIN_W'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
    endtask

    initial begin
`ifdef OVF_MON_IRQ_EN
        irq_exp = 1'b1;
`else
        irq_exp = 1'b0;
`endif
        reset = 1'b0; valid_in = 0; start = 0; stop = 0; rd_req = 0;
        rd_lane = 0; rd_sel = 0; window_len = 0;
        clr_flags();
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sticky", 32'(sticky), 0);
        check("rst_rdv", 32'(rd_valid), 0);
        check("rst_rdd", 32'(rd_data), 0);
        check("rst_irq", 32'(irq), 0);
        reset = 1'b1;
        tick();

        // window of 5 valid cycles, lane 2 sum_pos on three of them
        begin_win(5);
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1;
            sum_pos_ovf = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            tick();
            if (i < 4) check("win5_busy", 32'(busy), 1);
            if (i < 4) check("win5_nodone", 32'(done), 0);
        end
        check("win5_done", 32'(done), 1);
        check("win5_busy_fall", 32'(busy), 0);
        valid_in = 1'b0;
        clr_flags();
        tick();
        check("win5_done_pulse", 32'(done), 0);
        check("win5_sticky", 32'(sticky), 32'h4);
        rd(2, 0, 3, "rd_2_0");
        rd(2, 1, 0, "rd_2_1");
        rd(0, 0, 0, "rd_0_0");
        rd(3, 3, 0, "rd_3_3");
        rd(1, 2, 0, "rd_1_2");
        rd_req = 1'b0;
        tick();
        check("rd_idle_v", 32'(rd_valid), 0);

        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_done_ign", 32'(done), 0);
        check("stop_busy_ign", 32'(busy), 0);

        // unbounded window: only stop ends it
        begin_win(0);
        valid_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("unb_busy", 32'(busy & ~done), 1);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        valid_in = 1'b0;
        check("unb_done", 32'(done), 1);
        check("unb_busy_fall", 32'(busy), 0);
        tick();
        check("unb_done_once", 32'(done), 0);

        // stop coinciding with window end gives a single pulse
        begin_win(2);
        valid_in = 1'b1;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        valid_in = 1'b0;
        check("coinc_done", 32'(done), 1);
        tick();
        check("coinc_done_once", 32'(done), 0);
        check("coinc_busy", 32'(busy), 0);

        // saturation of lane 0 prod_neg with a read racing an increment
        begin_win(0);
        valid_in = 1'b1;
        prod_neg_ovf = 4'b0001;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                rd_req = 1'b1; rd_lane = 0; rd_sel = 3;
            end
            tick();
            if (i == 3) begin
                check("race_rd", 32'(rd_data), 2);
                rd_req = 1'b0;
            end
            if (i == 15) check("irq_pre", 32'(irq), 0);
            if (i == 16) check("irq_set", 32'(irq), 32'(irq_exp));
        end
        stop = 1'b1;
        valid_in = 1'b0;
        clr_flags();
        tick();
        stop = 1'b0;
        rd(0, 3, 15, "sat_rd_0_3");
        rd_req = 1'b0;
        check("irq_hold", 32'(irq), 32'(irq_exp));

        // simultaneous pos/neg, then invalid cycles hold everything
        begin_win(2);
        check("irq_clr", 32'(irq), 0);
        valid_in = 1'b1;
        sum_pos_ovf = 4'b0010;
        sum_neg_ovf = 4'b0010;
        tick();
        valid_in = 1'b0;
        sum_pos_ovf = 4'b1000; sum_neg_ovf = 4'b1000;
        prod_pos_ovf = 4'b1000; prod_neg_ovf = 4'b1000;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0;
            check("inval_busy", 32'(busy), 1);
        end
        check("inval_sticky", 32'(sticky), 32'h2);
        clr_flags();
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("inval_done", 32'(done), 1);
        rd(1, 0, 1, "both_1_0");
        rd(1, 1, 1, "both_1_1");
        rd(3, 0, 0, "inval_3_0");
        rd(3, 3, 0, "inval_3_3");
        rd_req = 1'b0;

        // reset mid-window
        begin_win(0);
        valid_in = 1'b1;
        sum_pos_ovf = 4'b0001;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        valid_in = 1'b0;
        clr_flags();
        check("mrst_busy", 32'(busy), 0);
        check("mrst_done", 32'(done), 0);
        check("mrst_sticky", 32'(sticky), 0);
        tick();
        check("mrst_nodone", 32'(done), 0);
        rd(0, 0, 0, "mrst_rd");
        rd_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/mac_overflow_monitor.md
# mac_overflow_monitor

Parametrised, synthesizable overflow-event monitor for the neural-network MAC array. It samples the per-lane sum and product overflow flags of `LANES` MAC units over a programmable window of valid cycles. It accumulates saturating per-lane, per-type event counts and sticky flags, and exposes the results through a one-cycle-latency read port. It sits beside `NeuralNetwork`, taps each `mac_unit`'s overflow outputs, and replaces ad-hoc testbench probing with on-chip statistics.

## Interface
- `LANES`, 4, number of MAC lanes monitored (matches `NU_COUNT`)
- `CNT_W`, 16, width of each event counter
- `WIN_W`, 16, width of window length and window counter
- `clk` in 1: single clock, all logic rising-edge
- `reset` in 1: synchronous, active-low reset
- `valid_in` in 1: overflow flags valid this cycle
- `sum_pos_ovf`, `sum_neg_ovf`, `prod_pos_ovf`, `prod_neg_ovf` in `LANES` each: per-lane flags, bit i = lane i
- `window_len` in `WIN_W`: valid cycles per window, sampled on `start`; 0 = unbounded
- `start` in 1: begin a new window (clears statistics)
- `stop` in 1: end current window early
- `busy` out 1: high in RUN
- `done` out 1: one-cycle pulse on entry to DONE
- `sticky` out `LANES`: lane i saw any overflow in current/last window
- `rd_req` in 1, `rd_lane` in `$clog2(LANES)`, `rd_sel` in 2 (0 sum_pos, 1 sum_neg, 2 prod_pos, 3 prod_neg)
- `rd_valid` out 1, `rd_data` out `CNT_W`: read response
- `irq` out 1: saturation interrupt (see Configuration)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE + `start`: clear all counters, `sticky`, window counter; latch `window_len`; → RUN.
- RUN: `start` ignored. Each cycle with `valid_in`: window counter +1. For each lane and type with its flag high, the counter +1, saturating at 2^CNT_W−1. The matching `sticky` bit is set.
- Pos and neg flags of one type high together in one lane: both counters increment (no arbitration).
- RUN → DONE when a valid cycle brings the window counter to `window_len` (nonzero), or when `stop` is high. That cycle's flags are still counted if `valid_in` is high. Simultaneous window end and `stop`: single transition, single `done` pulse.
- `window_len`=0: window never self-terminates; only `stop` ends it. Window counter saturates, no wrap.
- `stop` in IDLE/DONE: ignored.
- DONE: counters frozen; values held until next `start`.
- Read port is legal in every state. `rd_lane` ≥ `LANES` returns 0 with `rd_valid` still asserted.

## Timing
- Reset values: `busy`=0, `done`=0, `sticky`=0, `rd_valid`=0, `rd_data`=0, `irq`=0, all counters 0.
- Reset asserted mid-window: all state cleared on that edge; no `done` pulse.
- Flags sampled at edge N are visible in counters/`sticky` after edge N.
- `busy` rises the edge after `start`. `done` is high for exactly the cycle after the terminating edge, and `busy` falls at the same edge.
- Read: `rd_req` at edge N → `rd_valid`=1 and `rd_data` stable for the cycle after edge N. Returns the value registered before edge N (a read coinciding with an increment returns the pre-increment value). Back-to-back reads every cycle are supported.

## Configuration
- `OVF_MON_IRQ_EN` defined: `irq` is a registered level that sets the edge after any counter reaches 2^CNT_W−1. It clears only on `start` or reset.
- Not defined: saturation detection logic is omitted, and `irq` is tied to 0. Counters still saturate.

## Test plan
- Reset then `start` with `window_len`=5, 5 valid cycles, lane 2 `sum_pos_ovf` high on 3 of them → `done` pulse 1 cycle after 5th valid; read (2,0)=3; all other counters 0; `sticky`=4'b0100.
- `window_len`=0, valid every cycle for 100 cycles, `stop` at cycle 100 → `busy` stays 1 until `stop`, then `done` pulses once; no self-termination.
- `CNT_W`=4, lane 0 `prod_neg_ovf` high for 20 valid cycles → read (0,3)=15. With `OVF_MON_IRQ_EN`, `irq` rises the edge after the 15th event; without it, `irq`=0.
- Lane 1 `sum_pos_ovf` and `sum_neg_ovf` both high in one cycle → read (1,0)=1 and (1,1)=1.
- `valid_in` low while flags high → no counter or `sticky` change, window counter holds.
- Reset low mid-RUN after 3 events → next cycle `busy`=0, reads return 0, no `done`.
